// File: rtl/afb_pkg.sv
// Shared AFB accelerator-pipe definitions: word widths, field positions, FSM encoding.
// Request word helper builds the 74-bit pipe word from a register-level command.
package afb_pkg;

    localparam int REQ_W        = 74;
    localparam int RSP_W        = 33;
    localparam int ADDR_W       = 36;
    localparam int DATA_W       = 32;
    localparam int IDX_W        = 5;
    localparam int REQ_LOCK_BIT = 73;
    localparam int REQ_RNW_BIT  = 72;
    localparam int REQ_MASK_MSB = 71;
    localparam int REQ_MASK_LSB = 68;
    localparam int REQ_ADDR_MSB = 67;
    localparam int REQ_ADDR_LSB = 32;
    localparam int REQ_DATA_MSB = 31;
    localparam int RSP_ERR_BIT  = 32;
    localparam int CNT_W        = 16;

    localparam logic [3:0] BYTE_MASK_DEFAULT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_DELIVER  = 3'd3,
        ST_FLUSH    = 3'd4
    } afb_state_e;

    function automatic logic [REQ_W-1:0] build_req(
        input logic [ADDR_W-1:0] base,
        input logic              rnw,
        input logic [IDX_W-1:0]  idx,
        input logic [DATA_W-1:0] wdata
    );
        logic [REQ_W-1:0] w;
        w = '0;
        w[REQ_LOCK_BIT]                = 1'b0;
        w[REQ_RNW_BIT]                 = rnw;
        w[REQ_MASK_MSB:REQ_MASK_LSB]   = BYTE_MASK_DEFAULT;
        w[REQ_ADDR_MSB:REQ_ADDR_LSB]   = base | {{(ADDR_W-IDX_W-2){1'b0}}, idx, 2'b00};
        w[REQ_DATA_MSB:0]              = rnw ? '0 : wdata;
        return w;
    endfunction

endpackage

// File: rtl/afb_timeout_counter.sv
// Counts WAIT_RSP cycles without a response; expire pulses combinationally on the
// cycle the count reaches TIMEOUT_CYCLES, so an ack in that same cycle can still win.
module afb_timeout_counter
    import afb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == LAST);

endmodule

// File: rtl/afb_accelerator_initiator.sv
// Single-outstanding register initiator onto the AFB request/response pipes; 3-cycle
// minimum accept-to-rsp_valid, stalls on pipe acks and holds the result until rsp_ready.
module afb_accelerator_initiator
    import afb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 36'h0,
    parameter int unsigned       TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [IDX_W-1:0]  cmd_reg_index,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              AFB_ACCELERATOR_REQUEST_pipe_write_req,
    input  logic              AFB_ACCELERATOR_REQUEST_pipe_write_ack,
    output logic [REQ_W-1:0]  AFB_ACCELERATOR_REQUEST_pipe_write_data,
    output logic              AFB_ACCELERATOR_RESPONSE_pipe_read_req,
    input  logic              AFB_ACCELERATOR_RESPONSE_pipe_read_ack,
    input  logic [RSP_W-1:0]  AFB_ACCELERATOR_RESPONSE_pipe_read_data
);

    afb_state_e        state_q;
    logic              flush_q;
    logic              cmd_ready_q;
    logic              write_req_q;
    logic              read_req_q;
    logic [REQ_W-1:0]  req_data_q;
    logic              rnw_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_error_q;
    logic              rsp_timeout_q;

    logic wr_xfer;
    logic rd_xfer;
    logic tmo_load;
    logic tmo_enable;
    logic tmo_expire;

    assign wr_xfer    = write_req_q && AFB_ACCELERATOR_REQUEST_pipe_write_ack;
    assign rd_xfer    = read_req_q && AFB_ACCELERATOR_RESPONSE_pipe_read_ack;
    assign tmo_load   = (state_q == ST_SEND) && wr_xfer;
    assign tmo_enable = (state_q == ST_WAIT_RSP) && !rd_xfer;

    afb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .load   (tmo_load),
        .enable (tmo_enable),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            flush_q       <= 1'b0;
            cmd_ready_q   <= 1'b0;
            write_req_q   <= 1'b0;
            read_req_q    <= 1'b0;
            req_data_q    <= '0;
            rnw_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        req_data_q  <= build_req(BASE_ADDR, cmd_read, cmd_reg_index, cmd_wdata);
                        rnw_q       <= cmd_read;
                        write_req_q <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wr_xfer) begin
                        write_req_q <= 1'b0;
                        read_req_q  <= 1'b1;
                        state_q     <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    // Ack beats expiry when both land in the same cycle.
                    if (rd_xfer) begin
                        read_req_q    <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= rnw_q ? AFB_ACCELERATOR_RESPONSE_pipe_read_data[DATA_W-1:0] : '0;
                        rsp_error_q   <= AFB_ACCELERATOR_RESPONSE_pipe_read_data[RSP_ERR_BIT];
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_DELIVER;
                    end else if (tmo_expire) begin
                        read_req_q    <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        flush_q       <= 1'b1;
                        state_q       <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (flush_q) begin
                            read_req_q <= 1'b1;
                            state_q    <= ST_FLUSH;
                        end else begin
                            cmd_ready_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The late response to the timed-out request is dropped here.
                    if (rd_xfer) begin
                        read_req_q  <= 1'b0;
                        flush_q     <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready                              = cmd_ready_q;
    assign rsp_valid                              = rsp_valid_q;
    assign rsp_data                               = rsp_data_q;
    assign rsp_error                              = rsp_error_q;
    assign rsp_timeout                            = rsp_timeout_q;
    assign AFB_ACCELERATOR_REQUEST_pipe_write_req  = write_req_q;
    assign AFB_ACCELERATOR_REQUEST_pipe_write_data = req_data_q;
    assign AFB_ACCELERATOR_RESPONSE_pipe_read_req  = read_req_q;

endmodule

// File: tb/tb_afb_accelerator_initiator.sv
// Directed bench: main instance at default timeout, second instance with an 8-cycle timeout.
module tb_afb_accelerator_initiator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        cmd_valid, cmd_ready, cmd_read, rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [4:0]  cmd_reg_index;
    logic [31:0] cmd_wdata, rsp_data;
    logic        wr_req, wr_ack, rd_req, rd_ack;
    logic [73:0] wr_data;
    logic [32:0] rd_data;

    logic        t_cmd_valid, t_cmd_ready, t_cmd_read, t_rsp_valid, t_rsp_ready, t_rsp_error, t_rsp_timeout;
    logic [4:0]  t_cmd_reg_index;
    logic [31:0] t_cmd_wdata, t_rsp_data;
    logic        t_wr_req, t_wr_ack, t_rd_req, t_rd_ack;
    logic [73:0] t_wr_data;
    logic [32:0] t_rd_data;

    afb_accelerator_initiator dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_reg_index(cmd_reg_index), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .AFB_ACCELERATOR_REQUEST_pipe_write_req(wr_req),
        .AFB_ACCELERATOR_REQUEST_pipe_write_ack(wr_ack),
        .AFB_ACCELERATOR_REQUEST_pipe_write_data(wr_data),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_req(rd_req),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_ack(rd_ack),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_data(rd_data)
    );

    afb_accelerator_initiator #(.BASE_ADDR(36'h0), .TIMEOUT_CYCLES(8)) dut_to (
        .clk(clk), .reset(reset),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_read(t_cmd_read),
        .cmd_reg_index(t_cmd_reg_index), .cmd_wdata(t_cmd_wdata),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
        .rsp_error(t_rsp_error), .rsp_timeout(t_rsp_timeout),
        .AFB_ACCELERATOR_REQUEST_pipe_write_req(t_wr_req),
        .AFB_ACCELERATOR_REQUEST_pipe_write_ack(t_wr_ack),
        .AFB_ACCELERATOR_REQUEST_pipe_write_data(t_wr_data),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_req(t_rd_req),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_ack(t_rd_ack),
        .AFB_ACCELERATOR_RESPONSE_pipe_read_data(t_rd_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, wr_req, rd_req, wr_data, rsp_valid, rsp_error, rsp_timeout, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_main: got rdy=%b wreq=%b rreq=%b wdat=%h rv=%b re=%b rt=%b rd=%h want all 0",
                     cmd_ready, wr_req, rd_req, wr_data, rsp_valid, rsp_error, rsp_timeout, rsp_data);
        end
        checks++;
        if ({t_cmd_ready, t_wr_req, t_rd_req, t_wr_data, t_rsp_valid, t_rsp_error, t_rsp_timeout, t_rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_to: got rdy=%b wreq=%b rreq=%b wdat=%h rv=%b want all 0",
                     t_cmd_ready, t_wr_req, t_rd_req, t_wr_data, t_rsp_valid);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, t_cmd_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: got %b%b want 11", cmd_ready, t_cmd_ready);
        end
    endtask

    task automatic test_write;
        logic [73:0] exp_req;
        exp_req = {1'b0, 1'b0, 4'hF, 36'h0_0000_0014, 32'hDEADBEEF};
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_reg_index = 5'd5; cmd_wdata = 32'hDEADBEEF;
        wr_ack = 1'b1; rd_ack = 1'b1; rd_data = 33'h0_FFFFFFFF;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({wr_req, cmd_ready, wr_data} !== {1'b1, 1'b0, exp_req}) begin
            errors++;
            $display("FAIL write_req_word: got req=%b rdy=%b data=%h want 1 0 %h", wr_req, cmd_ready, wr_data, exp_req);
        end
        tick();
        checks++;
        if ({wr_req, rd_req, rsp_valid} !== 3'b010) begin
            errors++;
            $display("FAIL write_wait_state: got wreq/rreq/rv=%b%b%b want 010", wr_req, rd_req, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_error, rsp_timeout, rsp_data, rd_req} !== {3'b100, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL write_rsp_cycle4: got v=%b e=%b t=%b d=%h rreq=%b want 1 0 0 00000000 0",
                     rsp_valid, rsp_error, rsp_timeout, rsp_data, rd_req);
        end
        wr_ack = 1'b0; rd_ack = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL write_rsp_consumed: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read_delayed;
        logic [73:0] exp_req;
        logic ok;
        exp_req = {1'b0, 1'b1, 4'hF, 36'h0_0000_007C, 32'h0};
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_reg_index = 5'd31; cmd_wdata = 32'h11111111;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({wr_req, wr_data} !== {1'b1, exp_req}) begin
            errors++;
            $display("FAIL read_req_word: got req=%b data=%h want 1 %h", wr_req, wr_data, exp_req);
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_req !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL read_wait_hold: got rreq=%b rv=%b during wait want 1 0", rd_req, rsp_valid);
        end
        rd_ack = 1'b1; rd_data = 33'h0_12345678;
        tick();
        rd_ack = 1'b0;
        checks++;
        if ({rsp_valid, rsp_error, rsp_timeout, rsp_data} !== {3'b100, 32'h12345678}) begin
            errors++;
            $display("FAIL read_rsp: got v=%b e=%b t=%b d=%h want 1 0 0 12345678",
                     rsp_valid, rsp_error, rsp_timeout, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_rsp_consumed: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_send_stall;
        logic [73:0] exp_req;
        logic ok;
        exp_req = {1'b0, 1'b0, 4'hF, 36'h0_0000_000C, 32'h0000A5A5};
        t_cmd_valid = 1'b1; t_cmd_read = 1'b0; t_cmd_reg_index = 5'd3; t_cmd_wdata = 32'h0000A5A5;
        t_wr_ack = 1'b0;
        tick();
        t_cmd_valid = 1'b0; t_cmd_wdata = 32'h99999999; t_cmd_reg_index = 5'd17;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (t_wr_req !== 1'b1 || t_wr_data !== exp_req || t_rd_req !== 1'b0) ok = 1'b0;
            tick();
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL send_stall_stable: got req=%b data=%h want 1 %h", t_wr_req, t_wr_data, exp_req);
        end
        t_wr_ack = 1'b1;
        tick();
        t_wr_ack = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if ({t_rsp_valid, t_rd_req} !== 2'b01) begin
            errors++;
            $display("FAIL send_no_early_timeout: got v=%b rreq=%b want 0 1", t_rsp_valid, t_rd_req);
        end
        // Ack lands on the very cycle the counter hits its limit.
        t_rd_ack = 1'b1; t_rd_data = 33'h0_CAFEF00D;
        tick();
        t_rd_ack = 1'b0;
        checks++;
        if ({t_rsp_valid, t_rsp_error, t_rsp_timeout, t_rsp_data} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL ack_wins_at_limit: got v=%b e=%b t=%b d=%h want 1 0 0 00000000",
                     t_rsp_valid, t_rsp_error, t_rsp_timeout, t_rsp_data);
        end
        t_rsp_ready = 1'b1;
        tick();
        t_rsp_ready = 1'b0;
        checks++;
        if ({t_rsp_valid, t_rd_req, t_cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL ack_wins_no_flush: got v/rreq/rdy=%b%b%b want 001", t_rsp_valid, t_rd_req, t_cmd_ready);
        end
    endtask

    task automatic test_timeout;
        t_cmd_valid = 1'b1; t_cmd_read = 1'b1; t_cmd_reg_index = 5'd2; t_cmd_wdata = 32'h0;
        tick();
        t_cmd_valid = 1'b0;
        t_wr_ack = 1'b1;
        tick();
        t_wr_ack = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if ({t_rsp_valid, t_rd_req} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_not_before_8: got v=%b rreq=%b want 0 1", t_rsp_valid, t_rd_req);
        end
        tick();
        checks++;
        if ({t_rsp_valid, t_rsp_error, t_rsp_timeout, t_rsp_data, t_rd_req} !== {3'b111, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_rsp: got v=%b e=%b t=%b d=%h rreq=%b want 1 1 1 00000000 0",
                     t_rsp_valid, t_rsp_error, t_rsp_timeout, t_rsp_data, t_rd_req);
        end
        t_rsp_ready = 1'b1;
        tick();
        t_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({t_rsp_valid, t_rd_req, t_cmd_ready} !== 3'b010) begin
            errors++;
            $display("FAIL flush_waiting: got v/rreq/rdy=%b%b%b want 010", t_rsp_valid, t_rd_req, t_cmd_ready);
        end
        t_rd_ack = 1'b1; t_rd_data = 33'h0_55555555;
        tick();
        t_rd_ack = 1'b0;
        checks++;
        if ({t_rsp_valid, t_rd_req, t_cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_done: got v/rreq/rdy=%b%b%b want 001", t_rsp_valid, t_rd_req, t_cmd_ready);
        end
    endtask

    task automatic test_rsp_backpressure;
        logic ok;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_reg_index = 5'd1; cmd_wdata = 32'h0;
        wr_ack = 1'b1; rd_ack = 1'b1; rd_data = 33'h1_00000000;
        tick();
        cmd_read = 1'b0; cmd_reg_index = 5'd9; cmd_wdata = 32'h77777777;
        tick();
        tick();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, rsp_error, rsp_timeout, rsp_data, cmd_ready, wr_req} !== {3'b110, 32'h0, 2'b00}) ok = 1'b0;
            tick();
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold: got v=%b e=%b t=%b d=%h rdy=%b wreq=%b want 1 1 0 00000000 0 0",
                     rsp_valid, rsp_error, rsp_timeout, rsp_data, cmd_ready, wr_req);
        end
        checks++;
        if ({rsp_valid, rsp_error, cmd_ready} !== 3'b110) begin
            errors++;
            $display("FAIL backpressure_after5: got v/e/rdy=%b%b%b want 110", rsp_valid, rsp_error, cmd_ready);
        end
        cmd_valid = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, wr_req} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_release: got v/rdy/wreq=%b%b%b want 010", rsp_valid, cmd_ready, wr_req);
        end
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_reg_index = 5'd4; cmd_wdata = 32'h0;
        tick();
        cmd_valid = 1'b0;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        tick();
        checks++;
        if (rd_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_in_wait: got rreq=%b want 1", rd_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({cmd_ready, wr_req, rd_req, wr_data, rsp_valid, rsp_error, rsp_timeout, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_values: got rdy=%b wreq=%b rreq=%b wdat=%h rv=%b want all 0",
                     cmd_ready, wr_req, rd_req, wr_data, rsp_valid);
        end
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rd_req} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_release: got rdy/rv/rreq=%b%b%b want 100", cmd_ready, rsp_valid, rd_req);
        end
        rd_ack = 1'b1; rd_data = 33'h0_ABCDEF01;
        tick(); tick();
        rd_ack = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_reg_index = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;
        t_cmd_valid = 1'b0; t_cmd_read = 1'b0; t_cmd_reg_index = '0; t_cmd_wdata = '0; t_rsp_ready = 1'b0;
        t_wr_ack = 1'b0; t_rd_ack = 1'b0; t_rd_data = '0;
        test_reset();
        test_write();
        test_read_delayed();
        test_send_stall();
        test_timeout();
        test_rsp_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
